// File: rtl/pc_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle next-PC sequencer: NPC ops, instruction
// classes, FSM states and the per-cycle control bundle.
package pc_seq_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NPC_OP_W = 2;
    localparam int unsigned CLS_W    = 3;
    localparam int unsigned STATE_W  = 3;

    localparam logic [XLEN-1:0] TEXT_BASE_ADDRESS = 32'h0000_3000;

    typedef enum logic [NPC_OP_W-1:0] {
        NPC_PLUS4    = 2'b00,
        NPC_BRANCH   = 2'b01,
        NPC_JUMP_IMM = 2'b10,
        NPC_JUMP_REG = 2'b11
    } npc_op_e;

    typedef enum logic [CLS_W-1:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_J      = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_JR     = 3'd6,
        CLS_HALT   = 3'd7
    } cls_e;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Strobes driven by the sequencer in a given cycle.
    typedef struct packed {
        npc_op_e npc_op;
        logic    pc_we;
        logic    ir_we;
        logic    imem_req;
        logic    dmem_req;
        logic    dmem_wr;
        logic    rf_we;
        logic    halted;
    } ctrl_t;

endpackage

// File: rtl/pc_seq_ctrl_pc_reg.sv
// Architectural PC register: loads d on we, async reset to the text base.
module pc_seq_ctrl_pc_reg
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = TEXT_BASE_ADDRESS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC, the NPC op
// select, memory handshakes, write strobes and the retired-instruction count.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] TEXT_BASE = TEXT_BASE_ADDRESS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     npc,
    input  logic [CLS_W-1:0]    cls,
    input  logic                br_taken,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic [XLEN-1:0]     pc,
    output logic [NPC_OP_W-1:0] npc_op,
    output logic                pc_we,
    output logic                ir_we,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_wr,
    output logic                rf_we,
    output logic                halted,
    output logic [XLEN-1:0]     instret
);

    state_e          state_q, state_d;
    cls_e            cls_q;
    cls_e            cls_in;
    npc_op_e         pend_q, pend_d;
    logic [XLEN-1:0] instret_q;
    ctrl_t           ctrl;

    assign cls_in = cls_e'(cls);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pending write-back NPC op
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cls_in)
                    CLS_J, CLS_JR: state_d = ST_FETCH;
                    CLS_JAL: begin
                        state_d = ST_WB;
                        pend_d  = NPC_JUMP_IMM;
                    end
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (cls_q == CLS_BRANCH) begin
                    state_d = ST_FETCH;
                end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                    pend_d  = NPC_PLUS4;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (cls_q == CLS_STORE) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                        pend_d  = NPC_PLUS4;
                    end
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Strobes decoded from state and this cycle's inputs; silent while in reset
    always_comb begin
        ctrl        = '0;
        ctrl.npc_op = NPC_PLUS4;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    ctrl.imem_req = 1'b1;
                    ctrl.ir_we    = imem_ack;
                end
                ST_DECODE: begin
                    if (cls_in == CLS_J) begin
                        ctrl.npc_op = NPC_JUMP_IMM;
                        ctrl.pc_we  = 1'b1;
                    end else if (cls_in == CLS_JR) begin
                        ctrl.npc_op = NPC_JUMP_REG;
                        ctrl.pc_we  = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cls_q == CLS_BRANCH) begin
                        ctrl.npc_op = br_taken ? NPC_BRANCH : NPC_PLUS4;
                        ctrl.pc_we  = 1'b1;
                    end
                end
                ST_MEM: begin
                    ctrl.dmem_req = 1'b1;
                    ctrl.dmem_wr  = (cls_q == CLS_STORE);
                    ctrl.pc_we    = dmem_ack && (cls_q == CLS_STORE);
                end
                ST_WB: begin
                    ctrl.rf_we  = 1'b1;
                    ctrl.npc_op = pend_q;
                    ctrl.pc_we  = 1'b1;
                end
                ST_HALT: ctrl.halted = 1'b1;
                default: ;
            endcase
        end
    end

    // Decoded class, pending op and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_q     <= CLS_ALU;
            pend_q    <= NPC_PLUS4;
            instret_q <= '0;
        end else begin
            if (state_q == ST_DECODE) begin
                cls_q <= cls_in;
            end
            pend_q <= pend_d;
            if (ctrl.pc_we) begin
                instret_q <= instret_q + XLEN'(1);
            end
        end
    end

    pc_seq_ctrl_pc_reg #(
        .RESET_VAL (TEXT_BASE)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .we  (ctrl.pc_we),
        .d   (npc),
        .q   (pc)
    );

    assign npc_op   = ctrl.npc_op;
    assign pc_we    = ctrl.pc_we;
    assign ir_we    = ctrl.ir_we;
    assign imem_req = ctrl.imem_req;
    assign dmem_req = ctrl.dmem_req;
    assign dmem_wr  = ctrl.dmem_wr;
    assign rf_we    = ctrl.rf_we;
    assign halted   = ctrl.halted;
    assign instret  = instret_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Randomized bench for pc_seq_ctrl: per-instruction cycle counts, strobe counts,
// NPC op and PC/instret updates predicted from class and ack latencies.
module tb_pc_seq_ctrl;

    localparam logic [2:0] C_ALU = 3'd0, C_LOAD = 3'd1, C_STORE = 3'd2, C_BRANCH = 3'd3;
    localparam logic [2:0] C_J = 3'd4, C_JAL = 3'd5, C_JR = 3'd6, C_HALT = 3'd7;
    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk, rst;
    logic [31:0] npc;
    logic [2:0]  cls;
    logic        br_taken, imem_ack, dmem_ack;
    logic [31:0] pc, instret;
    logic [1:0]  npc_op;
    logic        pc_we, ir_we, imem_req, dmem_req, dmem_wr, rf_we, halted;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc = BASE;
    logic [31:0] exp_instret = 0;

    pc_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .npc      (npc),
        .cls      (cls),
        .br_taken (br_taken),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .pc       (pc),
        .npc_op   (npc_op),
        .pc_we    (pc_we),
        .ir_we    (ir_we),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .dmem_wr  (dmem_wr),
        .rf_we    (rf_we),
        .halted   (halted),
        .instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int base_cycles(input logic [2:0] c);
        case (c)
            C_J, C_JR:       return 2;
            C_BRANCH, C_JAL: return 3;
            C_ALU, C_STORE:  return 4;
            C_LOAD:          return 5;
            default:         return 0;
        endcase
    endfunction

    function automatic logic [1:0] exp_op(input logic [2:0] c, input logic b);
        case (c)
            C_BRANCH:    return b ? 2'b01 : 2'b00;
            C_J, C_JAL:  return 2'b10;
            C_JR:        return 2'b11;
            default:     return 2'b00;
        endcase
    endfunction

    function automatic logic [5:0] strobes();
        return {imem_req, dmem_req, pc_we, ir_we, rf_we, dmem_wr};
    endfunction

    // One instruction from FETCH to its pc_we cycle; acks answer after wi/wd wait cycles.
    task automatic run_instr(input logic [2:0] c, input int wi, input int wd,
                             input logic b, input logic [31:0] nv);
        int   icnt = 0, dcnt = 0, cyc = 0, nrf = 0, nir = 0, nreq = 0, nwr = 0;
        logic done = 1'b0;
        logic [1:0] op = 2'b00;
        bit   mem = (c == C_LOAD) || (c == C_STORE);
        cls = c; br_taken = b; npc = nv;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            imem_ack = imem_req ? (icnt == wi) : 1'($urandom);
            dmem_ack = dmem_req ? (dcnt == wd) : 1'($urandom);
            #1;
            if (cyc == 0) chk("fetch_req", 32'(imem_req), 32'd1);
            cyc++;
            if (imem_req && !imem_ack) icnt++;
            if (dmem_req && !dmem_ack) dcnt++;
            nrf += int'(rf_we); nir += int'(ir_we); nreq += int'(dmem_req); nwr += int'(dmem_wr);
            if (pc_we) begin
                done = 1'b1;
                op   = npc_op;
            end
        end
        chk("retired", 32'(done), 32'd1);
        chk("cycles", 32'(cyc), 32'(base_cycles(c) + wi + (mem ? wd : 0)));
        chk("npc_op", 32'(op), 32'(exp_op(c, b)));
        chk("rf_we", 32'(nrf), 32'((c == C_ALU || c == C_LOAD || c == C_JAL) ? 1 : 0));
        chk("ir_we", 32'(nir), 32'd1);
        chk("dmem_req", 32'(nreq), 32'(mem ? wd + 1 : 0));
        chk("dmem_wr", 32'(nwr), 32'((c == C_STORE) ? wd + 1 : 0));
        exp_pc = nv;
        exp_instret = exp_instret + 32'd1;
        @(posedge clk);
        #1;
        chk("pc", pc, exp_pc);
        chk("instret", instret, exp_instret);
    endtask

    // Reset hits while a LOAD is waiting on dmem_ack; the late ack must be ignored.
    task automatic reset_mid_mem();
        int icnt = 0, nmem = 0;
        cls = C_LOAD; br_taken = 1'b0; npc = $urandom;
        for (int k = 0; k < 32 && nmem < 2; k++) begin
            @(negedge clk);
            imem_ack = imem_req ? (icnt == 1) : 1'b0;
            dmem_ack = 1'b0;
            #1;
            if (imem_req && !imem_ack) icnt++;
            if (dmem_req) nmem++;
        end
        chk("mem_reached", 32'(nmem), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_pc", pc, BASE);
        chk("rst_instret", instret, 32'd0);
        exp_pc = BASE;
        exp_instret = 0;
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b1;
        #1;
        chk("post_rst_fetch", 32'(imem_req), 32'd1);
        chk("post_rst_quiet", 32'({dmem_req, pc_we, rf_we, ir_we}), 32'd0);
    endtask

    task automatic run_halt(input int wi);
        int   icnt = 0, cyc = 0, nwe = 0;
        logic seen = 1'b0;
        cls = C_HALT; npc = $urandom;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            imem_ack = imem_req ? (icnt == wi) : 1'($urandom);
            dmem_ack = 1'($urandom);
            #1;
            cyc++;
            if (imem_req && !imem_ack) icnt++;
            nwe += int'(pc_we);
            if (halted) seen = 1'b1;
        end
        chk("halt_cycle", 32'(cyc), 32'(wi + 3));
        chk("halt_no_pc_we", 32'(nwe), 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            br_taken = 1'($urandom); npc = $urandom; cls = 3'($urandom);
            #1;
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_strobes", 32'(strobes()), 32'd0);
            chk("halt_instret", instret, exp_instret);
            chk("halt_pc", pc, exp_pc);
        end
    endtask

    initial begin
        rst = 1'b1; npc = '0; cls = C_ALU; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #3;
        chk("reset_strobes", 32'({strobes(), halted}), 32'd0);
        chk("reset_pc", pc, BASE);
        chk("reset_instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_instr(C_ALU,    0, 0, 1'b0, 32'h0000_3004);
        run_instr(C_BRANCH, 0, 0, 1'b1, 32'h0000_3010);
        run_instr(C_BRANCH, 0, 0, 1'b0, 32'h0000_3014);
        run_instr(C_LOAD,   0, 3, 1'b0, 32'h0000_3018);
        run_instr(C_JAL,    0, 0, 1'b0, 32'h0000_4000);
        run_instr(C_JR,     0, 0, 1'b0, 32'h0000_301c);
        run_instr(C_STORE,  2, 1, 1'b0, 32'h0000_3020);

        reset_mid_mem();
        run_instr(C_ALU, 0, 0, 1'b0, 32'h0000_3004);

        for (int n = 0; n < 80; n++) begin
            run_instr(3'($urandom_range(6, 0)), int'($urandom_range(3, 0)),
                      int'($urandom_range(3, 0)), 1'($urandom), $urandom);
        end

        run_halt(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
